serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits, SHALL be >= 2.
REQ-002 Parameter DIGIT, default 1, bits added per clock, SHALL divide WIDTH exactly; violation is an elaboration error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin an operation; accepted only when ready=1.
REQ-006 a  input  WIDTH  first operand, sampled at acceptance.
REQ-007 b  input  WIDTH  second operand, sampled at acceptance.
REQ-008 cin  input  1  carry-in for add mode, sampled at acceptance.
REQ-009 sub  input  1  mode select at acceptance: 0 = a+b+cin, 1 = a-b (a + ~b + 1, cin ignored).
REQ-010 ready  output  1  high when a start will be accepted.
REQ-011 done  output  1  single-cycle pulse marking a new valid result.
REQ-012 sum  output  WIDTH  result, held stable until the next completion.
REQ-013 cout  output  1  carry out of MSB (for sub, 1 means no borrow).
REQ-014 overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE; ready = 1 in IDLE and DONE, 0 in RUN.
REQ-016 IDLE: start=1 at an edge -> latch a, b (b inverted if sub), carry register = (sub ? 1 : cin), digit counter = 0, go RUN; else stay IDLE.
REQ-017 RUN: each edge adds digit [counter*DIGIT +: DIGIT] of both operands plus carry register, writes that digit of an internal accumulator, updates carry register, increments counter.
REQ-018 RUN lasts exactly N = WIDTH/DIGIT cycles; on the edge processing digit N-1, go DONE and load sum, cout, overflow from the completed accumulator and carries.
REQ-019 Latency: start accepted at edge k -> done=1 in the cycle following edge k+N, with sum/cout/overflow valid in that same cycle.
REQ-020 DONE: done=1 for exactly one cycle; next edge -> RUN if start=1 (back-to-back, operands latched as in IDLE), else IDLE.
REQ-021 start, a, b, cin, sub SHALL be ignored while in RUN; no queuing.
REQ-022 sum, cout, overflow SHALL change only on the edge entering DONE; they hold through IDLE and any following RUN.
REQ-023 Arithmetic is modulo 2**WIDTH; carry out of the MSB digit goes to cout only, never wraps to the LSB.
REQ-024 Digit counter SHALL be $clog2(N) bits wide (minimum 1) and SHALL never exceed N-1.

Reset
REQ-025 reset_n=0 SHALL immediately, without waiting for clk, force state=IDLE, ready=1, done=0, sum=0, cout=0, overflow=0, counter=0, carry register=0.
REQ-026 Reset asserted during RUN SHALL abandon the operation; no done pulse is produced for it.
REQ-027 The first edge after reset_n deasserts SHALL be able to accept start.

Structure
REQ-028 Package serial_adder_pkg SHALL hold the FSM state enum type (IDLE, RUN, DONE).
REQ-029 One sub-module, digit_adder #(DIGIT), SHALL be a combinational DIGIT-bit ripple adder with ports a, b, cin, sum, cout, plus carry-into-MSB output for overflow; it is built from full_adder instances.
REQ-030 Exactly one digit_adder instance per serial_adder; no other arithmetic operators on operands.

Verification
REQ-031 WIDTH=8, DIGIT=1: a=8'h7F, b=8'h01, cin=0, sub=0 -> done 8 cycles after acceptance, sum=8'h80, cout=0, overflow=1.
REQ-032 WIDTH=8, DIGIT=1: a=8'hFF, b=8'h01, cin=0, sub=0 -> sum=8'h00, cout=1, overflow=0; then sub=1, a=8'h05, b=8'h07 back-to-back in DONE -> sum=8'hFE, cout=0, overflow=0, no IDLE cycle between.
REQ-033 WIDTH=8, DIGIT=4: a=8'hA5, b=8'h5A, cin=1 -> done 2 cycles after acceptance, sum=8'h00, cout=1, overflow=0.
REQ-034 start pulsed with new operands mid-RUN -> ignored; result equals the originally accepted operation; ready=0 throughout RUN.
REQ-035 reset_n asserted at RUN cycle 3 of WIDTH=8, DIGIT=1 -> outputs 0 and ready=1 immediately (asynchronously), no done pulse; a fresh start after release completes normally.
REQ-036 Exhaustive check at WIDTH=4, DIGIT in {1,2,4}: all a, b, cin, sub combinations compared against a reference model, including sum/cout/overflow.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Purpose: shared types and helpers for the digit-serial adder.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package serial_adder_pkg;

    // Controller states: IDLE waits for work, RUN walks the digits,
    // DONE presents the one-cycle completion pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width; a single-digit operation still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Purpose: DIGIT-bit combinational ripple adder, exposing carry into its MSB.
// Latency: combinational.
// Backpressure: none.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    // carry[i] is the carry into bit i; carry[DIGIT] leaves the digit.
    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    assign cout  = carry[DIGIT];
    // When this digit is the top of the word, this feeds overflow detection.
    assign c_msb = carry[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// Purpose: one-bit full adder cell used to build the digit ripple chain.
// Latency: combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Purpose: digit-serial add/subtract, DIGIT bits per clock through one digit_adder.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+WIDTH/DIGIT.
// Backpressure: ready low while running; start is ignored (not queued) until ready returns.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    // Reject parameter sets the digit walk cannot cover exactly.
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 2 and an exact multiple of DIGIT");
    end

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              step;
    logic              last;

    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  acc_next;
    int                idx;

    logic [DIGIT-1:0]  dig_a;
    logic [DIGIT-1:0]  dig_b;
    logic [DIGIT-1:0]  dig_sum;
    logic              dig_cout;
    logic              dig_cmsb;

    // The last digit is the one the counter sits on when it reaches N-1.
    assign last = (cnt == CW'(N - 1));

    // Bit offset of the digit currently being processed.
    always_comb begin
        idx = int'(cnt) * DIGIT;
    end

    // Select the current digit of each latched operand.
    always_comb begin
        dig_a = op_a[idx +: DIGIT];
        dig_b = op_b[idx +: DIGIT];
    end

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a     (dig_a),
        .b     (dig_b),
        .cin   (carry),
        .sum   (dig_sum),
        .cout  (dig_cout),
        .c_msb (dig_cmsb)
    );

    // Accumulator with the current digit merged in, so the final result
    // can be loaded straight into sum on the completing edge.
    always_comb begin
        acc_next             = acc;
        acc_next[idx +: DIGIT] = dig_sum;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; DONE can chain straight into RUN.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture and digit walk; subtraction is a + ~b + 1, so the
    // inverted subtrahend is latched and the carry seeded with 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (step) begin
            acc   <= acc_next;
            carry <= dig_cout;
            if (last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Result registers only move on the edge that enters DONE; the top
    // digit's carry goes to cout and never wraps back into the LSB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (step && last) begin
            sum      <= acc_next;
            cout     <= dig_cout;
            overflow <= dig_cmsb ^ dig_cout;
        end
    end

    // The digit counter must stay inside the operand.
    a_cnt_range: assert property (@(posedge clk) disable iff (!reset_n)
        cnt <= CW'(N - 1));

    // Completion is a single-cycle pulse.
    a_done_pulse: assert property (@(posedge clk) disable iff (!reset_n)
        done |=> !done);

endmodule

// File: tb/tb_serial_adder.sv
// Purpose: scoreboard bench for serial_adder at WIDTH=8 (DIGIT 1,4) and WIDTH=4 (DIGIT 1,2,4).
// Latency: expected done edge is recorded per operation and checked by the monitor.
// Backpressure: stimulus only issues start when the target instance is ready.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // WIDTH=8 instances share operands, each has its own start.
    logic [7:0] a8, b8;
    logic       cin8, sub8, start8d1, start8d4;
    logic       rdy8d1, dn8d1, co8d1, ov8d1;
    logic [7:0] s8d1;
    logic       rdy8d4, dn8d4, co8d4, ov8d4;
    logic [7:0] s8d4;

    // WIDTH=4 instances are driven identically for the exhaustive sweep.
    logic [3:0] a4, b4;
    logic       cin4, sub4, start4;
    logic [2:0] rdy4, dn4, co4, ov4;
    logic [3:0] s4 [3];

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .reset_n(reset_n), .start(start8d1), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .ready(rdy8d1), .done(dn8d1), .sum(s8d1), .cout(co8d1), .overflow(ov8d1));

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .reset_n(reset_n), .start(start8d4), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .ready(rdy8d4), .done(dn8d4), .sum(s8d4), .cout(co8d4), .overflow(ov8d4));

    serial_adder #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
        .clk(clk), .reset_n(reset_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .ready(rdy4[0]), .done(dn4[0]), .sum(s4[0]), .cout(co4[0]), .overflow(ov4[0]));

    serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .reset_n(reset_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .ready(rdy4[1]), .done(dn4[1]), .sum(s4[1]), .cout(co4[1]), .overflow(ov4[1]));

    serial_adder #(.WIDTH(4), .DIGIT(4)) u_w4d4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .ready(rdy4[2]), .done(dn4[2]), .sum(s4[2]), .cout(co4[2]), .overflow(ov4[2]));

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         due;
    } exp_t;

    // Queue per instance: 0=w8d1 1=w8d4 2=w4d1 3=w4d2 4=w4d4.
    exp_t  q [5][$];
    string nm [5] = '{"w8d1", "w8d4", "w4d1", "w4d2", "w4d4"};

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    always @(posedge clk) edges++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic observe(input int id, input logic dn, input logic [7:0] s,
                           input logic co, input logic ov);
        exp_t e;
        if (dn === 1'b1) begin
            checks++;
            if (q[id].size() == 0) begin
                errors++;
                $display("FAIL unexpected_done %s: done=1 at edge %0d, expected no operation in flight",
                         nm[id], edges);
            end else begin
                e = q[id].pop_front();
                if ({s, co, ov} !== {e.sum, e.cout, e.ovf} || edges != e.due) begin
                    errors++;
                    $display("FAIL result %s: got sum=%h cout=%b ovf=%b at edge %0d, expected sum=%h cout=%b ovf=%b at edge %0d",
                             nm[id], s, co, ov, edges, e.sum, e.cout, e.ovf, e.due);
                end
            end
        end
    endtask

    // Monitor: compare every completion against the head of its queue.
    always @(negedge clk) begin
        observe(0, dn8d1, s8d1, co8d1, ov8d1);
        observe(1, dn8d4, s8d4, co8d4, ov8d4);
        for (int k = 0; k < 3; k++) begin
            observe(2 + k, dn4[k], {4'h0, s4[k]}, co4[k], ov4[k]);
        end
    end

    // Independent model for the 4-bit sweep: sign-rule overflow.
    function automatic exp_t ref4(input logic [3:0] x, input logic [3:0] y,
                                  input logic c, input logic s);
        logic [3:0] yy;
        logic [4:0] t;
        exp_t       r;
        yy    = s ? ~y : y;
        t     = {1'b0, x} + {1'b0, yy} + {4'h0, (s ? 1'b1 : c)};
        r.sum = {4'h0, t[3:0]};
        r.cout = t[4];
        r.ovf = (x[3] == yy[3]) && (t[3] != x[3]);
        r.due = 0;
        return r;
    endfunction

    // Issue one WIDTH=8 operation; called at a negedge with the target ready.
    task automatic go8(input int id, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tc, input logic ts,
                       input logic [7:0] es, input logic ec, input logic eo, input bit want);
        exp_t e;
        a8 = ta; b8 = tb_; cin8 = tc; sub8 = ts;
        if (id == 0) start8d1 = 1'b1;
        else         start8d4 = 1'b1;
        if (want) begin
            e.sum  = es;
            e.cout = ec;
            e.ovf  = eo;
            e.due  = edges + 1 + ((id == 0) ? 8 : 2);
            q[id].push_back(e);
        end
        @(negedge clk);
        start8d1 = 1'b0;
        start8d4 = 1'b0;
    endtask

    initial begin
        exp_t e;
        reset_n = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; start8d1 = 1'b0; start8d4 = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; start4 = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_ready", {31'h0, rdy8d1}, 32'h1);
        chk("reset_done",  {31'h0, dn8d1},  32'h0);
        chk("reset_outs",  {22'h0, s8d1, co8d1, ov8d1}, 32'h0);
        reset_n = 1'b1;

        // 7F + 01 on the first edge after reset release: signed overflow.
        go8(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("run_ready_low", {31'h0, rdy8d1}, 32'h0);
            @(negedge clk);
        end
        chk("done_ready_high", {31'h0, rdy8d1}, 32'h1);

        // FF + 01 chained from DONE, then 05 - 07 chained from DONE.
        go8(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        go8(0, 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
        chk("b2b_in_run", {31'h0, rdy8d1}, 32'h0);
        repeat (8) @(negedge clk);
        @(negedge clk);

        // 12 + 34 with a start pulse and new operands mid-run.
        go8(0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("midrun_ready_low", {31'h0, rdy8d1}, 32'h0);
            chk("midrun_sum_held", {24'h0, s8d1}, 32'h0000_00FE);
            if (i == 2) begin
                a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8d1 = 1'b1;
            end else begin
                start8d1 = 1'b0;
            end
            @(negedge clk);
        end
        start8d1 = 1'b0;
        chk("midrun_done_ready", {31'h0, rdy8d1}, 32'h1);
        repeat (2) @(negedge clk);

        // Reset in RUN cycle 3: operation abandoned, outputs clear at once.
        go8(0, 8'h55, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_ready", {31'h0, rdy8d1}, 32'h1);
        chk("async_rst_done",  {31'h0, dn8d1},  32'h0);
        chk("async_rst_outs",  {22'h0, s8d1, co8d1, ov8d1}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        go8(0, 8'h60, 8'h50, 1'b1, 1'b0, 8'hB1, 1'b0, 1'b1, 1'b1);
        repeat (10) @(negedge clk);

        // Four-bit digits on the 8-bit datapath.
        go8(1, 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        go8(1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        go8(1, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Exhaustive 4-bit sweep across all three digit sizes.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    for (int is = 0; is < 2; is++) begin
                        a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); sub4 = 1'(is);
                        e = ref4(a4, b4, cin4, sub4);
                        for (int k = 0; k < 3; k++) begin
                            e.due = edges + 1 + (4 >> k);
                            q[2 + k].push_back(e);
                        end
                        start4 = 1'b1;
                        @(negedge clk);
                        start4 = 1'b0;
                        repeat (5) @(negedge clk);
                    end
                end
            end
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk({"drained_", nm[k]}, q[k].size(), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
